// File: rtl/mux_rr_reg.sv
// Registered N-channel selector with valid/ready on every input and the output.
// Fixed mode follows an external select; round-robin mode rotates fairly over valid channels.
module mux_rr_reg #(
    parameter int N_CH = 4,
    parameter int W    = 8,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mode,
    input  logic [SEL_W-1:0]    sel,
    input  logic [N_CH*W-1:0]   in_data,
    input  logic [N_CH-1:0]     in_valid,
    output logic [N_CH-1:0]     in_ready,
    output logic [W-1:0]        out_data,
    output logic [SEL_W-1:0]    out_ch,
    output logic                out_valid,
    input  logic                out_ready
);

    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] rr_grant;
    logic [SEL_W-1:0] grant;
    logic             rr_ok;
    logic             fix_ok;
    logic             grant_ok;
    logic             load_en;
    logic [W-1:0]     grant_data;
    int               rr_idx;

    assign load_en = !out_valid || out_ready;

    // An out-of-range sel matches no channel, so it never grants.
    always_comb begin
        fix_ok = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (sel == SEL_W'(i)) begin
                fix_ok = in_valid[i];
            end
        end
    end

    // Search starts just after the last winner and wraps at N_CH, so the
    // last winner is considered only when nobody else is waiting.
    always_comb begin
        rr_ok    = 1'b0;
        rr_grant = '0;
        rr_idx   = 0;
        for (int k = 1; k <= N_CH; k++) begin
            rr_idx = int'(ptr) + k;
            if (rr_idx >= N_CH) begin
                rr_idx = rr_idx - N_CH;
            end
            if (!rr_ok && in_valid[rr_idx]) begin
                rr_ok    = 1'b1;
                rr_grant = SEL_W'(rr_idx);
            end
        end
    end

    assign grant    = mode ? rr_grant : sel;
    assign grant_ok = mode ? rr_ok    : fix_ok;

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant == SEL_W'(i)) begin
                grant_data = in_data[i*W +: W];
            end
        end
    end

    // Gated by rst_n so no producer sees a handshake while the block is held in reset.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N_CH; i++) begin
            in_ready[i] = rst_n && load_en && grant_ok && (grant == SEL_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= SEL_W'(N_CH - 1);
        end else if (load_en) begin
            if (grant_ok) begin
                out_data  <= grant_data;
                out_ch    <= grant;
                out_valid <= 1'b1;
                if (mode) begin
                    ptr <= grant;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_rr_reg.sv
// Directed bench for mux_rr_reg: 4-channel default, 3-channel (non power of two) and 2x1-bit instances.
module tb_mux_rr_reg;

    logic clk;
    logic rst_n;

    logic        mode4, out_ready4, out_valid4;
    logic [1:0]  sel4, out_ch4;
    logic [31:0] in_data4;
    logic [3:0]  in_valid4, in_ready4;
    logic [7:0]  out_data4;

    logic        mode3, out_ready3, out_valid3;
    logic [1:0]  sel3, out_ch3;
    logic [23:0] in_data3;
    logic [2:0]  in_valid3, in_ready3;
    logic [7:0]  out_data3;

    logic        mode2, out_ready2, out_valid2;
    logic        sel2, out_ch2;
    logic [1:0]  in_data2;
    logic [1:0]  in_valid2, in_ready2;
    logic        out_data2;

    int n_checks;
    int n_fail;

    mux_rr_reg #(.N_CH(4), .W(8)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .mode(mode4), .sel(sel4),
        .in_data(in_data4), .in_valid(in_valid4), .in_ready(in_ready4),
        .out_data(out_data4), .out_ch(out_ch4), .out_valid(out_valid4), .out_ready(out_ready4)
    );

    mux_rr_reg #(.N_CH(3), .W(8)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3),
        .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .out_data(out_data3), .out_ch(out_ch3), .out_valid(out_valid3), .out_ready(out_ready3)
    );

    mux_rr_reg #(.N_CH(2), .W(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .mode(mode2), .sel(sel2),
        .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
        .out_data(out_data2), .out_ch(out_ch2), .out_valid(out_valid2), .out_ready(out_ready2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp_mux;
        logic [1:0] rr_seq[6];
        logic [1:0] alt_seq[4];
        logic [1:0] wrap_seq[4];

        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        mode4 = 1'b0; sel4 = 2'd0; in_data4 = 32'h44_A5_22_11; in_valid4 = 4'b0000; out_ready4 = 1'b1;
        mode3 = 1'b0; sel3 = 2'd0; in_data3 = 24'h33_22_11;    in_valid3 = 3'b000;  out_ready3 = 1'b1;
        mode2 = 1'b0; sel2 = 1'b0; in_data2 = 2'b00;           in_valid2 = 2'b00;   out_ready2 = 1'b1;

        #2;
        check("reset_out_valid", 32'(out_valid4), 32'd0);
        check("reset_out_data", 32'(out_data4), 32'd0);
        check("reset_in_ready", 32'(in_ready4), 32'd0);
        tick();
        tick();
        #2 rst_n = 1'b1;
        tick();

        // fixed mode, sel=2
        sel4 = 2'd2; in_valid4 = 4'b0110;
        #1 check("fix_in_ready", 32'(in_ready4), 32'h4);
        tick();
        check("fix_out_data", 32'(out_data4), 32'hA5);
        check("fix_out_ch", 32'(out_ch4), 32'd2);
        check("fix_out_valid", 32'(out_valid4), 32'd1);
        sel4 = 2'd3;
        #1 check("fix_invalid_ready", 32'(in_ready4), 32'h0);
        tick();
        check("fix_invalid_valid", 32'(out_valid4), 32'd0);
        check("fix_invalid_hold", 32'(out_data4), 32'hA5);

        // round-robin: ptr still at reset value 3, so rotation starts at ch0
        mode4 = 1'b1; in_valid4 = 4'b1111;
        rr_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        for (int i = 0; i < 6; i++) begin
            tick();
            check("rr_all_ch", 32'(out_ch4), 32'(rr_seq[i]));
        end
        check("rr_all_data", 32'(out_data4), 32'h22);
        // last winner was ch1, so the next valid after it is ch3
        in_valid4 = 4'b1010;
        alt_seq = '{2'd3, 2'd1, 2'd3, 2'd1};
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rr_alt_ch", 32'(out_ch4), 32'(alt_seq[i]));
        end

        // backpressure while out_ch=1 is held
        in_valid4 = 4'b1111; out_ready4 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 check("bp_in_ready", 32'(in_ready4), 32'h0);
            tick();
            check("bp_out_ch", 32'(out_ch4), 32'd1);
            check("bp_out_data", 32'(out_data4), 32'h22);
            check("bp_out_valid", 32'(out_valid4), 32'd1);
        end
        out_ready4 = 1'b1;
        #1 check("bp_release_ready", 32'(in_ready4), 32'h4);
        tick();
        check("bp_release_ch", 32'(out_ch4), 32'd2);
        check("bp_release_data", 32'(out_data4), 32'hA5);

        // asynchronous reset mid-cycle with a word held
        check("pre_reset_valid", 32'(out_valid4), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_out_valid", 32'(out_valid4), 32'd0);
        check("async_out_data", 32'(out_data4), 32'd0);
        check("async_out_ch", 32'(out_ch4), 32'd0);
        check("async_in_ready", 32'(in_ready4), 32'd0);
        #1 rst_n = 1'b1;
        #1 check("post_reset_ready", 32'(in_ready4), 32'h1);
        tick();
        check("post_reset_ch", 32'(out_ch4), 32'd0);
        check("post_reset_valid", 32'(out_valid4), 32'd1);

        // N_CH=3: out-of-range select
        mode3 = 1'b0; sel3 = 2'd1; in_valid3 = 3'b111;
        tick();
        check("n3_fix_ch", 32'(out_ch3), 32'd1);
        check("n3_fix_valid", 32'(out_valid3), 32'd1);
        sel3 = 2'd3;
        #1 check("n3_oor_ready", 32'(in_ready3), 32'h0);
        tick();
        check("n3_oor_valid", 32'(out_valid3), 32'd0);
        // N_CH=3 round-robin wraps at 3, not 4
        mode3 = 1'b1;
        wrap_seq = '{2'd0, 2'd1, 2'd2, 2'd0};
        for (int i = 0; i < 4; i++) begin
            tick();
            check("n3_rr_ch", 32'(out_ch3), 32'(wrap_seq[i]));
        end

        // N_CH=2, W=1: d = x ? y : z
        mode2 = 1'b0; in_valid2 = 2'b11;
        exp_mux = 8'b1100_1010;
        for (int i = 0; i < 8; i++) begin
            logic [2:0] xyz;
            xyz = 3'(i);
            sel2 = xyz[2];
            in_data2 = {xyz[1], xyz[0]};
            tick();
            check("mux3_out", 32'(out_data2), 32'(exp_mux[i]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
